// File: rtl/hybrid_cross_pipe.sv
// Multi-lane valid/ready pipeline that cross-combines each channel with its
// neighbour at every stage transfer, plus a wrapping output transfer counter.
module hybrid_cross_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int STAGES   = 3,
    parameter int MODE     = 0,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHANNELS*WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]            xfer_count
);

    localparam int LAST = STAGES - 1;
    localparam int DW   = CHANNELS * WIDTH;

    if (WIDTH < 1 || CHANNELS < 1 || STAGES < 1 || CNT_W < 1) begin : g_bad_size
        $error("hybrid_cross_pipe: WIDTH, CHANNELS, STAGES and CNT_W must all be >= 1");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("hybrid_cross_pipe: MODE must be 0 (NAND-pair) or 1 (XOR-rotate)");
    end

    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] rot;
        logic [WIDTH-1:0] res;
        for (int i = 0; i < WIDTH; i++) begin
            rot[i] = y[(i + WIDTH - 1) % WIDTH];
        end
        case (MODE)
            32'sd0:  res = ~(x & y);
            32'sd1:  res = x ^ rot;
            default: res = ~(x & y);
        endcase
        return res;
    endfunction

    // Channel c pairs with channel (c+1) mod CHANNELS; one lane pairs with itself.
    function automatic logic [DW-1:0] cross_row(input logic [DW-1:0] row);
        logic [DW-1:0] res;
        res = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            res[c*WIDTH +: WIDTH] = combine(row[c*WIDTH +: WIDTH],
                                            row[((c + 1) % CHANNELS)*WIDTH +: WIDTH]);
        end
        return res;
    endfunction

    logic [STAGES-1:0] v_r;
    logic [DW-1:0]     a_r [STAGES];
    logic [CNT_W-1:0]  xfer_count_r;
    logic [STAGES-1:0] adv_s;
    logic              accept_s;

    // Advance chain resolved from the output back; any empty stage pulls from its predecessor.
    always_comb begin
        adv_s       = '0;
        adv_s[LAST] = v_r[LAST] & out_ready;
        for (int s = STAGES - 2; s >= 0; s--) begin
            adv_s[s] = v_r[s] & (~v_r[s+1] | adv_s[s+1]);
        end
    end

    assign in_ready = ~v_r[0] | adv_s[0];
    assign accept_s = in_valid & in_ready;

    // Stage registers and transfer counter; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r          <= '0;
            xfer_count_r <= '0;
            for (int s = 0; s < STAGES; s++) begin
                a_r[s] <= '0;
            end
        end else begin
            if (accept_s) begin
                a_r[0] <= in_data;
                v_r[0] <= 1'b1;
            end else if (adv_s[0]) begin
                v_r[0] <= 1'b0;
            end else begin
                v_r[0] <= v_r[0];
            end

            for (int s = 1; s < STAGES; s++) begin
                if (adv_s[s-1]) begin
                    a_r[s] <= cross_row(a_r[s-1]);
                    v_r[s] <= 1'b1;
                end else if (adv_s[s]) begin
                    v_r[s] <= 1'b0;
                end else begin
                    v_r[s] <= v_r[s];
                end
            end

            if (v_r[LAST] && out_ready) begin
                xfer_count_r <= xfer_count_r + CNT_W'(1'b1);
            end else begin
                xfer_count_r <= xfer_count_r;
            end
        end
    end

    assign out_valid  = v_r[LAST];
    assign out_data   = a_r[LAST];
    assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_hybrid_cross_pipe.sv
// Directed and scoreboarded bench for hybrid_cross_pipe: NAND-pair, XOR-rotate
// and 2-bit-counter instances share one clock and reset.
module tb_hybrid_cross_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv0 = 1'b0, ir0, ov0, or0 = 1'b0;
    logic [15:0] id0 = 16'h0000, od0;
    logic [15:0] xc0;
    logic        iv1 = 1'b0, ir1, ov1, or1 = 1'b0;
    logic [15:0] id1 = 16'h0000, od1;
    logic [15:0] xc1;
    logic        iv2 = 1'b0, ir2, ov2, or2 = 1'b0;
    logic [15:0] id2 = 16'h0000, od2;
    logic [1:0]  xc2;

    int n_checks = 0;
    int n_fail   = 0;

    hybrid_cross_pipe #(.WIDTH(8), .CHANNELS(2), .STAGES(3), .MODE(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .xfer_count(xc0));
    hybrid_cross_pipe #(.WIDTH(8), .CHANNELS(2), .STAGES(3), .MODE(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .xfer_count(xc1));
    hybrid_cross_pipe #(.WIDTH(8), .CHANNELS(2), .STAGES(3), .MODE(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .xfer_count(xc2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One XOR-rotate transfer for the 2x8 configuration.
    function automatic logic [15:0] m1_step(input logic [15:0] x);
        logic [7:0] a, b;
        a = x[7:0];
        b = x[15:8];
        return {b ^ {a[6:0], a[7]}, a ^ {b[6:0], b[7]}};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        or0 = 1'b0; or1 = 1'b0; or2 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iv0 = 1'b1; id0 = 16'hA5A5; or0 = 1'b0;
        tick(); tick();
        iv0 = 1'b0; rst_n = 1'b1;
        n_checks++; if (ov0 !== 1'b0)      begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov0); end
        n_checks++; if (od0 !== 16'h0000)  begin n_fail++; $display("FAIL reset_out_data got %h want 0000", od0); end
        n_checks++; if (xc0 !== 16'd0)     begin n_fail++; $display("FAIL reset_xfer_count got %0d want 0", xc0); end
        n_checks++; if (ir0 !== 1'b1)      begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir0); end
    endtask

    task automatic test_nand_mode();
        do_reset();
        or0 = 1'b1; id0 = 16'h0FFF; iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
        n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL nand_latency1 got %b want 0", ov0); end
        tick();
        n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL nand_latency2 got %b want 0", ov0); end
        tick();
        n_checks++; if (ov0 !== 1'b1)     begin n_fail++; $display("FAIL nand_out_valid got %b want 1", ov0); end
        n_checks++; if (od0 !== 16'h0F0F) begin n_fail++; $display("FAIL nand_out_data got %h want 0f0f", od0); end
        tick();
        n_checks++; if (xc0 !== 16'd1) begin n_fail++; $display("FAIL nand_xfer_count got %0d want 1", xc0); end
        n_checks++; if (ov0 !== 1'b0)  begin n_fail++; $display("FAIL nand_drained got %b want 0", ov0); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h0005; exp_w[1] = 16'h0000; exp_w[2] = 16'h0005;
        do_reset();
        or1 = 1'b1; iv1 = 1'b1;
        id1 = 16'h0001; tick();
        id1 = 16'h0000; tick();
        id1 = 16'h0001; tick();
        iv1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ov1 !== 1'b1)     begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want 1", i, ov1); end
            n_checks++; if (od1 !== exp_w[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, od1, exp_w[i]); end
            tick();
        end
        n_checks++; if (ov1 !== 1'b0)  begin n_fail++; $display("FAIL b2b_drained got %b want 0", ov1); end
        n_checks++; if (xc1 !== 16'd3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", xc1); end
    endtask

    task automatic test_stall();
        logic [15:0] w   [4];
        logic [15:0] exp_w [4];
        int n;
        w[0] = 16'h1234; w[1] = 16'hABCD; w[2] = 16'h00FF; w[3] = 16'h5A5A;
        exp_w[0] = 16'h1010; exp_w[1] = 16'h8989; exp_w[2] = 16'h0000; exp_w[3] = 16'h5A5A;
        do_reset();
        or0 = 1'b0; iv0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id0 = w[i];
            tick();
        end
        id0 = w[3];
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ir0 !== 1'b0)     begin n_fail++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, ir0); end
            n_checks++; if (od0 !== 16'h1010) begin n_fail++; $display("FAIL stall_hold[%0d] got %h want 1010", i, od0); end
            tick();
        end
        or0 = 1'b1;
        #1;
        n_checks++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b want 1", ir0); end
        n = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (ov0) begin
                if (n < 4) begin
                    n_checks++; if (od0 !== exp_w[n]) begin n_fail++; $display("FAIL stall_order[%0d] got %h want %h", n, od0, exp_w[n]); end
                end else begin
                    n_checks++; n_fail++; $display("FAIL stall_extra got %h want no output", od0);
                end
                n++;
            end
            tick();
            if (cyc == 0) iv0 = 1'b0;
        end
        n_checks++; if (n != 4)        begin n_fail++; $display("FAIL stall_words got %0d want 4", n); end
        n_checks++; if (xc0 !== 16'd4) begin n_fail++; $display("FAIL stall_count got %0d want 4", xc0); end
    endtask

    task automatic test_bubbles();
        logic [15:0] exp_q [$];
        logic [15:0] e;
        int sent, recv, cyc;
        do_reset();
        sent = 0; recv = 0; cyc = 0;
        while (recv < 1000 && cyc < 20000) begin
            iv1 = (sent < 1000) && ($urandom_range(3) != 0);
            id1 = 16'($urandom);
            or1 = ($urandom_range(2) != 0);
            #1;
            if (iv1 && ir1) begin
                exp_q.push_back(m1_step(m1_step(id1)));
                sent++;
            end
            if (ov1 && or1) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL bubble_dup got %h want nothing", od1);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (od1 !== e) begin n_fail++; $display("FAIL bubble_data[%0d] got %h want %h", recv, od1, e); end
                end
                recv++;
            end
            tick();
            cyc++;
        end
        iv1 = 1'b0;
        n_checks++; if (recv != 1000)          begin n_fail++; $display("FAIL bubble_received got %0d want 1000", recv); end
        n_checks++; if (xc1 !== 16'(recv))     begin n_fail++; $display("FAIL bubble_count got %0d want %0d", xc1, recv); end
    endtask

    task automatic test_wrap();
        do_reset();
        or2 = 1'b1; iv2 = 1'b1; id2 = 16'h3C3C;
        repeat (5) tick();
        iv2 = 1'b0;
        repeat (6) tick();
        n_checks++; if (xc2 !== 2'd1) begin n_fail++; $display("FAIL wrap_count got %0d want 1", xc2); end
        n_checks++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL wrap_drained got %b want 0", ov2); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        or1 = 1'b0; iv1 = 1'b1;
        id1 = 16'h0001; tick();
        id1 = 16'h0002; tick();
        iv1 = 1'b0;
        tick();
        n_checks++; if (ov1 !== 1'b1) begin n_fail++; $display("FAIL midflight_loaded got %b want 1", ov1); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; or1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (ov1 !== 1'b0 || od1 !== 16'h0000) begin n_fail++; $display("FAIL midflight_out[%0d] got %b/%h want 0/0000", i, ov1, od1); end
            tick();
        end
        n_checks++; if (xc1 !== 16'd0) begin n_fail++; $display("FAIL midflight_count got %0d want 0", xc1); end
    endtask

    initial begin
        test_reset();
        test_nand_mode();
        test_back_to_back();
        test_stall();
        test_bubbles();
        test_wrap();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
